// File: rtl/vending_machine_change.sv
// Vending FSM with configurable price, coin-by-coin change,
// cancel/refund and rejection of coins inserted while busy.
module vending_machine_change #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                C,
  input  logic                R,
  input  logic                cancel,
  output logic                L,
  output logic                change_half,
  output logic                change_one,
  output logic                coin_reject,
  output logic                ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    REFUND  = 2'b11
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_W   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_W   = CREDIT_W'(2);

  state_t              st_q, st_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] sum;
  logic                busy;
  logic                reject_q;

  assign busy = st_q[1];
  assign sum  = credit_q + CREDIT_W'(C)
              + CREDIT_W'({R, 1'b0});

  // State, credit and reject registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      credit_q <= credit_d;
      reject_q <= busy & (C | R);
    end
  end

  // Next state and next credit
  always_comb begin
    st_d     = st_q;
    credit_d = credit_q;
    unique case (st_q)
      IDLE, COLLECT: begin
        credit_d = sum;
        if (sum >= PRICE_W)
          st_d = VEND;
        else if (cancel && sum != '0)
          st_d = REFUND;
        else if (sum != '0)
          st_d = COLLECT;
        else
          st_d = IDLE;
      end
      VEND: begin
        credit_d = credit_q - PRICE_W;
        st_d = (credit_q > PRICE_W) ? REFUND : IDLE;
      end
      REFUND: begin
        if (credit_q >= TWO_W)
          credit_d = credit_q - TWO_W;
        else
          credit_d = '0;
        st_d = (credit_q > TWO_W) ? REFUND : IDLE;
      end
      default: begin
        st_d     = IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign L           = (st_q == VEND);
  assign change_one  = (st_q == REFUND) && (credit_q >= TWO_W);
  assign change_half = (st_q == REFUND) && (credit_q == ONE_W);
  assign coin_reject = reject_q;
  assign ready       = ~busy;
  assign credit      = credit_q;
  assign state       = st_q;

endmodule
